ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter. Sends command bytes to a keyboard, e.g. 0xED set-LEDs or 0xFF reset.
//  Pairs with the ps2 receiver on the same open-drain clk/data pins; the top level forms the tristates.
//  Runs in the system clk domain. Filters the raw pins, sequences the inhibit/request/bit/ack protocol,
//  and reports done or error through a valid/ready handshake.
// PARAMETERS
//  INHIBIT_CYCLES  10000      clk cycles ps2_clk is held low before the request (100 us @ 100 MHz)
//  DEBOUNCE        8          consecutive stable clk cycles before a filtered pin level changes
//  TIMEOUT_CYCLES  2000000    max clk cycles between device clock edges, or waiting for idle (20 ms)
// PORTS
//  clk          in   1  system clock, rising edge
//  rst_n        in   1  asynchronous active-low reset
//  i_data       in   8  command byte; sampled when i_valid & o_ready
//  i_valid      in   1  request to send i_data
//  o_ready      out  1  high only in IDLE
//  ps2_clk_in   in   1  raw ps2_clk pin level (asynchronous)
//  ps2_data_in  in   1  raw ps2_data pin level (asynchronous)
//  ps2_clk_oe   out  1  1 = pull ps2_clk low, 0 = release
//  ps2_data_oe  out  1  1 = pull ps2_data low, 0 = release
//  o_busy       out  1  transfer in progress; the receiver ignores the pins while this is high
//  o_done       out  1  one-cycle pulse: byte sent and acknowledged
//  o_err        out  1  one-cycle pulse: no ack or timeout
// BEHAVIOUR
//  Reset: state IDLE, both oe=0, o_ready=1, o_busy=0, o_done=0, o_err=0, filters preset to 1.
//  Reset mid-transfer releases both lines immediately and emits no pulse.
//  Input filter
//   - 2-FF synchroniser, then a counter; the filtered level flips after DEBOUNCE equal samples.
//   - fall/rise = one-cycle strobes on filtered clk. Pin-to-strobe latency is 2+DEBOUNCE cycles.
//  Handshake
//   - Accept on i_valid & o_ready. Latch the byte; parity = ~^i_data (odd parity).
//   - o_ready drops the next cycle. i_valid while busy is ignored, not queued.
//  FSM
//   - IDLE    -> INHIBIT on accept.
//   - INHIBIT: clk_oe=1 for INHIBIT_CYCLES cycles; data_oe=1 is asserted in the final cycle.
//   - REQ: clk_oe=0, data_oe=1 (start bit); bit index = 0.
//   - SEND: on each fall, data_oe = ~bit. Bits are d0..d7, then parity, then stop (data_oe=0).
//           After the stop bit is applied at fall 10 -> ACK.
//   - ACK: on fall 11, sample filtered data. 0 -> WAIT_IDLE; 1 -> ERR.
//   - WAIT_IDLE: filtered clk=1 and data=1 -> DONE.
//   - DONE: o_done=1 for one cycle, then IDLE.
//   - ERR: oe=0, o_err=1 for one cycle, then IDLE.
//  Timeout: counter cleared on entering REQ and on every fall. Reaching TIMEOUT_CYCLES in
//   REQ/SEND/ACK/WAIT_IDLE -> ERR.
//  o_busy = state != IDLE. ps2_clk_oe is only ever 1 in INHIBIT. Both oe outputs are registered.
//  A fall during INHIBIT is ignored (the host owns clk). Counters saturate and never wrap.
// TESTING  (INHIBIT_CYCLES=20, DEBOUNCE=4, TIMEOUT_CYCLES=500; the bench device model clocks
//           at a 24-cycle half-period and samples data on the rise)
//  1 Send 0xED, device acks -> device sees bits 1,0,1,1,0,1,1,1, parity 1, stop 1;
//    o_done one pulse; o_ready back to 1.
//  2 Send 0x01 -> parity bit 0; send 0xFF -> parity bit 1; both o_done.
//  3 Device omits the ack (data high at fall 11) -> o_err one pulse, no o_done, both oe=0.
//  4 Device never clocks after the request -> o_err exactly 500 cycles after REQ entry; lines released.
//  5 rst_n low during bit 4 -> oe=0 asynchronously, no o_done/o_err, next 0xF4 transfer succeeds.
//  6 i_valid held during a transfer with a new byte -> only the first byte is sent;
//    the second is accepted only after o_ready=1.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: filters the raw open-drain pins, runs the inhibit/request/bit/ack
// sequence for one command byte and reports completion or failure as one-cycle pulses.

module ps2_host_tx_filter #(
  parameter int DEBOUNCE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic level_o
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;

  // NOTE: every always_comb target gets a default first so no latch is inferred.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], pin_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int DEBOUNCE       = 8,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE,
    S_DONE,
    S_ERR
  } state_t;

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] INH_PRE  = CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [9:0]       frame_q, frame_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             clk_prev_q;
  logic             clk_level, data_level, clk_fall;
  logic             timer_run;

  ps2_host_tx_filter #(.DEBOUNCE(DEBOUNCE)) u_clk_filter (
    .clk     (clk),
    .rst_n   (rst_n),
    .pin_i   (ps2_clk_in),
    .level_o (clk_level)
  );

  ps2_host_tx_filter #(.DEBOUNCE(DEBOUNCE)) u_data_filter (
    .clk     (clk),
    .rst_n   (rst_n),
    .pin_i   (ps2_data_in),
    .level_o (data_level)
  );

  // Strobe lands in the same cycle the filtered level flips.
  assign clk_fall = clk_prev_q & ~clk_level;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    frame_d   = frame_q;
    data_oe_d = data_oe_q;
    timer_run = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          state_d   = S_INHIBIT;
          frame_d   = {1'b1, ~^i_data, i_data};
          cnt_d     = '0;
          data_oe_d = (INHIBIT_CYCLES == 1);
        end
      end
      S_INHIBIT: begin
        if (cnt_q >= INH_LAST) begin
          state_d   = S_REQ;
          cnt_d     = '0;
          bit_idx_d = '0;
          data_oe_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == INH_PRE) data_oe_d = 1'b1;
        end
      end
      S_REQ, S_SEND: begin
        if (clk_fall) begin
          // Frame order is d0..d7, parity, stop; the pin is driven with the inverted bit.
          data_oe_d = ~frame_q[bit_idx_q];
          bit_idx_d = bit_idx_q + 4'd1;
          cnt_d     = '0;
          state_d   = (bit_idx_q == 4'd9) ? S_ACK : S_SEND;
        end else begin
          timer_run = 1'b1;
        end
      end
      S_ACK: begin
        if (clk_fall) begin
          cnt_d   = '0;
          state_d = data_level ? S_ERR : S_WAIT_IDLE;
        end else begin
          timer_run = 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_level && data_level) begin
          state_d = S_DONE;
        end else begin
          timer_run = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (timer_run) begin
      if (cnt_q >= TMO_LAST) begin
        state_d = S_ERR;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (state_d == S_ERR || state_d == S_IDLE) data_oe_d = 1'b0;
    clk_oe_d = (state_d == S_INHIBIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      frame_q    <= '0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      clk_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      frame_q    <= frame_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      clk_prev_q <= clk_level;
    end
  end

  assign o_ready     = (state_q == S_IDLE);
  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = (state_q == S_DONE);
  assign o_err       = (state_q == S_ERR);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain bus with a device model that clocks the frame and checks
// each sampled bit against a scoreboard of expected frame bits queued when a byte is offered.

module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int DEB  = 4;
  localparam int TMO  = 500;
  localparam int HALF = 24;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       i_valid = 1'b0;
  logic       o_ready, ps2_clk_oe, ps2_data_oe, o_busy, o_done, o_err;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_pin, ps2_data_pin;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  bit exp_q[$];

  assign ps2_clk_pin  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_pin = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .DEBOUNCE       (DEB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .ps2_clk_in  (ps2_clk_pin),
    .ps2_data_in (ps2_data_pin),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_done) done_cnt <= done_cnt + 1;
    if (o_err)  err_cnt  <= err_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_frame(input logic [7:0] b);
    int ones;
    ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(b[i]);
      if (b[i]) ones++;
    end
    exp_q.push_back((ones % 2) == 0);
    exp_q.push_back(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_data  = b;
    i_valid = 1'b1;
    push_frame(b);
    tick(1);
    i_valid = 1'b0;
    check("ready_drop", o_ready, 1'b0);
    check("busy_set", o_busy, 1'b1);
  endtask

  // Device side: waits out the inhibit, checks the start bit, then clocks falls 1..11.
  // stop_fall > 0 leaves clk held low at that fall and returns early.
  task automatic device(input bit ack, input int stop_fall);
    int n;
    bit first_d, last_d;
    n = 0;
    while (!ps2_clk_oe && n < 200) begin
      tick(1);
      n++;
    end
    check("inhibit_seen", ps2_clk_oe, 1'b1);
    first_d = ps2_data_oe;
    last_d  = 1'b0;
    n = 0;
    while (ps2_clk_oe && n < 1000) begin
      last_d = ps2_data_oe;
      n++;
      tick(1);
    end
    check("inhibit_len", n, INH);
    check("inhibit_data_first", first_d, 1'b0);
    check("inhibit_data_last", last_d, 1'b1);
    tick(10);
    check("start_bit", ps2_data_pin, exp_q.pop_front());
    for (int k = 1; k <= 11; k++) begin
      if (k == stop_fall) begin
        dev_clk_low = 1'b1;
        return;
      end
      dev_clk_low = 1'b1;
      tick(HALF);
      dev_clk_low = 1'b0;
      if (k <= 10) check($sformatf("frame_bit%0d", k), ps2_data_pin, exp_q.pop_front());
      if (k == 10 && ack) begin
        tick(HALF / 2);
        dev_data_low = 1'b1;
        tick(HALF / 2);
      end else if (k == 11) begin
        tick(4);
        dev_data_low = 1'b0;
      end else begin
        tick(HALF);
      end
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!o_ready && n < 300) begin
      tick(1);
      n++;
    end
    check("back_to_ready", o_ready, 1'b1);
    tick(2);
  endtask

  initial begin
    int d0, e0, n;

    // Reset state
    tick(3);
    check("rst_ready", o_ready, 1'b1);
    check("rst_busy", o_busy, 1'b0);
    check("rst_clk_oe", ps2_clk_oe, 1'b0);
    check("rst_data_oe", ps2_data_oe, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_err", o_err, 1'b0);
    rst_n = 1'b1;
    tick(5);

    // 0xED with ack
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hED);
    device(1'b1, 0);
    wait_ready();
    check("ed_done", done_cnt - d0, 1);
    check("ed_no_err", err_cnt - e0, 0);
    check("ed_clk_oe", ps2_clk_oe, 1'b0);
    check("ed_data_oe", ps2_data_oe, 1'b0);

    // Parity extremes
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'h01);
    device(1'b1, 0);
    wait_ready();
    send_byte(8'hFF);
    device(1'b1, 0);
    wait_ready();
    check("parity_done", done_cnt - d0, 2);
    check("parity_no_err", err_cnt - e0, 0);

    // Missing ack
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'h3C);
    device(1'b0, 0);
    wait_ready();
    check("noack_err", err_cnt - e0, 1);
    check("noack_no_done", done_cnt - d0, 0);
    check("noack_clk_oe", ps2_clk_oe, 1'b0);
    check("noack_data_oe", ps2_data_oe, 1'b0);

    // Device never clocks: timeout measured from REQ entry
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hAA);
    n = 0;
    while (ps2_clk_oe && n < 200) begin
      tick(1);
      n++;
    end
    n = 0;
    while (!o_err && n < 1000) begin
      tick(1);
      n++;
    end
    check("timeout_cycles", n, TMO);
    check("timeout_clk_oe", ps2_clk_oe, 1'b0);
    check("timeout_data_oe", ps2_data_oe, 1'b0);
    exp_q.delete();
    wait_ready();
    check("timeout_err", err_cnt - e0, 1);
    check("timeout_no_done", done_cnt - d0, 0);

    // Reset while d4 is on the wire
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'h0F);
    device(1'b1, 5);
    tick(12);
    check("pre_rst_data_oe", ps2_data_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_async_clk_oe", ps2_clk_oe, 1'b0);
    check("rst_async_data_oe", ps2_data_oe, 1'b0);
    dev_clk_low = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(40);
    check("rst_no_done", done_cnt - d0, 0);
    check("rst_no_err", err_cnt - e0, 0);
    check("rst_ready_again", o_ready, 1'b1);
    exp_q.delete();
    send_byte(8'hF4);
    device(1'b1, 0);
    wait_ready();
    check("f4_done", done_cnt - d0, 1);
    check("f4_no_err", err_cnt - e0, 0);

    // i_valid held through a transfer with a new byte
    d0 = done_cnt; e0 = err_cnt;
    i_data  = 8'h55;
    i_valid = 1'b1;
    push_frame(8'h55);
    tick(1);
    i_data = 8'hC3;
    push_frame(8'hC3);
    check("hold_ready_low", o_ready, 1'b0);
    device(1'b1, 0);
    n = 0;
    while (!o_ready && n < 300) begin
      tick(1);
      n++;
    end
    check("hold_ready_seen", o_ready, 1'b1);
    device(1'b1, 0);
    i_valid = 1'b0;
    wait_ready();
    check("hold_done", done_cnt - d0, 2);
    check("hold_no_err", err_cnt - e0, 0);
    check("hold_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
